// File: rtl/datapath_seq.sv
// Multi-cycle register file + 16-op ARM-ordered ALU with persistent NZCV flags,
// sequenced IDLE -> READ -> EXEC -> WB. Optional barrel shifter on operand B: DATAPATH_SHIFTER_EN.
module datapath_seq #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_rn,
    input  logic [ADDR_W-1:0] i_rm,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [3:0]        i_alu_op,
    input  logic              i_set_flags,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [WIDTH-1:0]  i_ld_data,
`ifdef DATAPATH_SHIFTER_EN
    input  logic [1:0]                 i_shift_type,
    input  logic [$clog2(WIDTH)-1:0]   i_shift_amt,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_zero_flag,
    output logic              o_carry_flag,
    output logic              o_overflow_flag,
    output logic              o_negative_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   r_regs [NUM_REGS];
    logic [ADDR_W-1:0]  r_rn;
    logic [ADDR_W-1:0]  r_rm;
    logic [ADDR_W-1:0]  r_rd;
    logic [3:0]         r_op;
    logic               r_sf;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_n;
    logic               r_z;
    logic               r_c;
    logic               r_v;

    logic [WIDTH-1:0]   w_b_op;
    logic               w_sh_c;
    logic               w_sh_v;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic               w_cin;
    logic               w_arith;
    logic [WIDTH-1:0]   w_log;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_v;
    logic               w_cmp;
    logic               w_upd;

    // State register with registered handshake outputs derived from the next state
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_WB);
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_READ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_READ: w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef DATAPATH_SHIFTER_EN
    localparam int SH_W = $clog2(WIDTH);
    logic [1:0]         r_sh_type;
    logic [SH_W-1:0]    r_sh_amt;
    logic [SH_W-1:0]    w_rot_amt;
    logic [2*WIDTH-1:0] w_rot;

    // Shift-field capture with start
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sh_type <= 2'd0;
            r_sh_amt  <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_sh_type <= i_shift_type;
            r_sh_amt  <= i_shift_amt;
        end else begin
            r_sh_type <= r_sh_type;
            r_sh_amt  <= r_sh_amt;
        end
    end

    // Barrel shifter; carry is the last bit shifted out (a zero amount is a pass-through)
    always_comb begin
        w_b_op    = r_b;
        w_sh_c    = 1'b0;
        w_sh_v    = 1'b0;
        // A truncated WIDTH of zero (power-of-two widths) makes this a no-op
        w_rot_amt = (r_sh_amt >= SH_W'(WIDTH)) ? (r_sh_amt - SH_W'(WIDTH)) : r_sh_amt;
        w_rot     = {r_b, r_b} >> w_rot_amt;
        if (r_sh_amt != '0) begin
            w_sh_v = 1'b1;
            case (r_sh_type)
                2'd0: {w_sh_c, w_b_op} = {1'b0, r_b} << r_sh_amt;
                2'd1: {w_b_op, w_sh_c} = {r_b, 1'b0} >> r_sh_amt;
                2'd2: {w_b_op, w_sh_c} = $signed({r_b, 1'b0}) >>> r_sh_amt;
                default: begin
                    w_b_op = w_rot[WIDTH-1:0];
                    w_sh_c = w_rot[WIDTH-1];
                end
            endcase
        end else begin
            w_b_op = r_b;
        end
    end
`else
    // No shifter: operand B passes straight through and never produces a carry
    always_comb begin
        w_b_op = r_b;
        w_sh_c = 1'b0;
        w_sh_v = 1'b0;
    end
`endif

    // ALU: subtractions are A + ~B + cin so the adder carry is the ARM NOT-borrow
    always_comb begin
        w_x     = r_a;
        w_y     = w_b_op;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        w_log   = '0;
        case (r_op)
            4'h2, 4'hA: begin w_y = ~w_b_op; w_cin = 1'b1; end
            4'h3:       begin w_x = w_b_op; w_y = ~r_a; w_cin = 1'b1; end
            4'h4, 4'hB: w_cin = 1'b0;
            4'h5:       w_cin = r_c;
            4'h6:       begin w_y = ~w_b_op; w_cin = r_c; end
            4'h7:       begin w_x = w_b_op; w_y = ~r_a; w_cin = r_c; end
            4'h0, 4'h8: begin w_arith = 1'b0; w_log = r_a & w_b_op; end
            4'h1, 4'h9: begin w_arith = 1'b0; w_log = r_a ^ w_b_op; end
            4'hC:       begin w_arith = 1'b0; w_log = r_a | w_b_op; end
            4'hD:       begin w_arith = 1'b0; w_log = w_b_op; end
            4'hE:       begin w_arith = 1'b0; w_log = r_a & ~w_b_op; end
            default:    begin w_arith = 1'b0; w_log = ~w_b_op; end
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        w_res = w_arith ? w_sum[WIDTH-1:0] : w_log;
        w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
        w_cmp = (r_op[3:2] == 2'b10);
        w_upd = w_cmp | r_sf;
    end

    // Datapath: operand capture, register file, result and flags
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_op     <= 4'd0;
            r_sf     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rn <= i_rn;
                        r_rm <= i_rm;
                        r_rd <= i_rd;
                        r_op <= i_alu_op;
                        r_sf <= i_set_flags;
                    end else if (i_ld_en) begin
                        r_regs[i_ld_addr] <= i_ld_data;
                    end else begin
                        r_sf <= r_sf;
                    end
                end
                ST_READ: begin
                    r_a <= r_regs[r_rn];
                    r_b <= r_regs[r_rm];
                end
                ST_EXEC: begin
                    r_result <= w_res;
                    if (w_upd) begin
                        r_n <= w_res[WIDTH-1];
                        r_z <= (w_res == '0);
                        if (w_arith) begin
                            r_c <= w_sum[WIDTH];
                            r_v <= w_v;
                        end else if (w_sh_v) begin
                            r_c <= w_sh_c;
                        end else begin
                            r_c <= r_c;
                        end
                    end else begin
                        r_n <= r_n;
                    end
                end
                ST_WB: begin
                    if (!w_cmp) begin
                        r_regs[r_rd] <= r_result;
                    end else begin
                        r_rd <= r_rd;
                    end
                end
                default: r_rd <= r_rd;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_result        = r_result;
    assign o_zero_flag     = r_z;
    assign o_carry_flag    = r_c;
    assign o_overflow_flag = r_v;
    assign o_negative_flag = r_n;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: expected results are queued at issue and
// compared when done rises; registers are observed through MOV read-backs.
module tb_datapath_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rn, rm, rd, alu_op;
    logic        sf;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [1:0]  sh_type;
    logic [4:0]  sh_amt;
    logic        busy, done;
    logic [31:0] result;
    logic        zf, cf, vf, nf;

    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    datapath_seq #(.WIDTH(32), .NUM_REGS(16)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_rn            (rn),
        .i_rm            (rm),
        .i_rd            (rd),
        .i_alu_op        (alu_op),
        .i_set_flags     (sf),
        .i_ld_en         (ld_en),
        .i_ld_addr       (ld_addr),
        .i_ld_data       (ld_data),
`ifdef DATAPATH_SHIFTER_EN
        .i_shift_type    (sh_type),
        .i_shift_amt     (sh_amt),
`endif
        .o_busy          (busy),
        .o_done          (done),
        .o_result        (result),
        .o_zero_flag     (zf),
        .o_carry_flag    (cf),
        .o_overflow_flag (vf),
        .o_negative_flag (nf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] nzcv);
        chk({tag, "_nzcv"}, {28'd0, nf, zf, cf, vf}, {28'd0, nzcv});
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Issue one op in IDLE and follow it for 4 cycles; poke=1 also hammers start/ld_en
    // and scrambles the operand fields while busy, all of which must be ignored.
    task automatic do_op(input string tag, input logic [3:0] rn_v, input logic [3:0] rm_v,
                         input logic [3:0] rd_v, input logic [3:0] op_v, input logic sf_v,
                         input logic [31:0] exp, input logic poke);
        start = 1'b1; rn = rn_v; rm = rm_v; rd = rd_v; alu_op = op_v; sf = sf_v;
        exp_q.push_back(exp);
        if (poke) begin
            ld_en = 1'b1; ld_addr = rd_v; ld_data = 32'hDEAD_BEEF;
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = poke;
            ld_en = poke;
            if (poke) begin
                rn = 4'hE; rm = 4'hE; rd = 4'hE; alu_op = 4'hF; sf = 1'b1;
            end
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done"}, {31'd0, done}, (c == 3) ? 32'd1 : 32'd0);
            if (done && exp_q.size() > 0) begin
                chk({tag, "_result"}, result, exp_q.pop_front());
            end
        end
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        do_op(tag, a, a, a, 4'hD, 1'b0, exp, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rn = 4'd0; rm = 4'd0; rd = 4'd0; alu_op = 4'd0;
        sf = 1'b0; ld_en = 1'b0; ld_addr = 4'd0; ld_data = 32'd0;
        sh_type = 2'd0; sh_amt = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_bd", {30'd0, busy, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk_flags("reset", 4'b0000);

        // ADD with busy-time interference
        load(4'd1, 32'd5);
        load(4'd2, 32'd3);
        do_op("add", 4'd1, 4'd2, 4'd3, 4'h4, 1'b1, 32'd8, 1'b1);
        chk_flags("add", 4'b0000);
        rd_reg("add_r3", 4'd3, 32'd8);
        rd_reg("poke_r14", 4'hE, 32'd0);

        // SUB borrow then ADC with C=0
        load(4'd1, 32'd3);
        load(4'd2, 32'd5);
        do_op("sub", 4'd1, 4'd2, 4'd4, 4'h2, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk_flags("sub", 4'b1000);
        do_op("adc0", 4'd1, 4'd2, 4'd5, 4'h5, 1'b1, 32'd8, 1'b0);
        chk_flags("adc0", 4'b0000);

        // Signed overflow, then CMP writes no register
        load(4'd1, 32'h7FFF_FFFF);
        load(4'd2, 32'd1);
        do_op("addv", 4'd1, 4'd2, 4'd6, 4'h4, 1'b1, 32'h8000_0000, 1'b0);
        chk_flags("addv", 4'b1001);
        do_op("cmp", 4'd1, 4'd1, 4'd6, 4'hA, 1'b0, 32'd0, 1'b0);
        chk_flags("cmp", 4'b0110);
        rd_reg("cmp_r6", 4'd6, 32'h8000_0000);

        // Back-to-back read-after-write
        do_op("raw_add", 4'd1, 4'd2, 4'd7, 4'h4, 1'b0, 32'h8000_0000, 1'b0);
        do_op("raw_mov", 4'd0, 4'd7, 4'd8, 4'hD, 1'b0, 32'h8000_0000, 1'b0);
        chk_flags("nosf", 4'b0110);

        // Logical ops keep C and V
        do_op("cmn", 4'd1, 4'd2, 4'd9, 4'hB, 1'b0, 32'h8000_0000, 1'b0);
        chk_flags("cmn", 4'b1001);
        do_op("eor", 4'd1, 4'd1, 4'd9, 4'h1, 1'b1, 32'd0, 1'b0);
        chk_flags("eor", 4'b0101);
        do_op("cmp2", 4'd1, 4'd1, 4'd9, 4'hA, 1'b0, 32'd0, 1'b0);
        do_op("mvn", 4'd0, 4'd2, 4'd10, 4'hF, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk_flags("mvn", 4'b1010);

        // Remaining ops with C=1
        do_op("sbc1", 4'd1, 4'd2, 4'd11, 4'h6, 1'b0, 32'h7FFF_FFFE, 1'b0);
        do_op("rsc1", 4'd1, 4'd2, 4'd11, 4'h7, 1'b0, 32'h8000_0002, 1'b0);
        do_op("rsb", 4'd1, 4'd2, 4'd11, 4'h3, 1'b0, 32'h8000_0002, 1'b0);
        do_op("bic", 4'd1, 4'd2, 4'd11, 4'hE, 1'b0, 32'h7FFF_FFFE, 1'b0);
        do_op("orr", 4'd1, 4'd2, 4'd11, 4'hC, 1'b0, 32'h7FFF_FFFF, 1'b0);
        do_op("and", 4'd1, 4'd2, 4'd11, 4'h0, 1'b0, 32'd1, 1'b0);
        do_op("tst", 4'd1, 4'd2, 4'd11, 4'h8, 1'b0, 32'd1, 1'b0);
        chk_flags("tst", 4'b0010);
        do_op("teq", 4'd1, 4'd1, 4'd11, 4'h9, 1'b0, 32'd0, 1'b0);
        chk_flags("teq", 4'b0110);
        rd_reg("tst_r11", 4'd11, 32'd1);

        // Carry-out boundaries
        load(4'd12, 32'hFFFF_FFFF);
        do_op("addc", 4'd12, 4'd2, 4'd13, 4'h4, 1'b1, 32'd0, 1'b0);
        chk_flags("addc", 4'b0110);
        do_op("adc1", 4'd2, 4'd2, 4'd13, 4'h5, 1'b1, 32'd3, 1'b0);
        chk_flags("adc1", 4'b0000);
        do_op("sbc0", 4'd2, 4'd2, 4'd13, 4'h6, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk_flags("sbc0", 4'b1000);
        do_op("rsc0", 4'd2, 4'd12, 4'd13, 4'h7, 1'b0, 32'hFFFF_FFFD, 1'b0);

        // Reset during EXEC aborts the op
        start = 1'b1; rn = 4'd1; rm = 4'd2; rd = 4'd12; alu_op = 4'h4; sf = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_exec_bd", {30'd0, busy, done}, 32'd0);
        chk("rst_exec_result", result, 32'd0);
        chk_flags("rst_exec", 4'b0000);
        tick();
        chk("rst_exec_nodone", {31'd0, done}, 32'd0);
        rd_reg("rst_r1", 4'd1, 32'd0);
        rd_reg("rst_r12", 4'd12, 32'd0);

`ifdef DATAPATH_SHIFTER_EN
        load(4'd2, 32'd1);
        sh_type = 2'd0; sh_amt = 5'd4;
        do_op("lsl4", 4'd0, 4'd2, 4'd3, 4'hD, 1'b1, 32'h0000_0010, 1'b0);
        chk_flags("lsl4", 4'b0000);
        load(4'd2, 32'h8000_0001);
        sh_type = 2'd3; sh_amt = 5'd1;
        do_op("ror1", 4'd0, 4'd2, 4'd3, 4'hD, 1'b1, 32'hC000_0000, 1'b0);
        chk_flags("ror1", 4'b1010);
        sh_type = 2'd0; sh_amt = 5'd0;
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
